scramble_lanes: RTL and testbench

SCRAMBLE_LANES -- requirements
Module: scramble_lanes

---
 rtl/scramble_lanes_pkg.sv | 49 ++++
 rtl/scramble_lanes_lane.sv | 72 +++++++
 rtl/scramble_lanes.sv | 49 ++++
 tb/tb_scramble_lanes.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/scramble_lanes_pkg.sv
// rtl/scramble_lanes_pkg.sv - shared constants and LFSR helpers for the lane scrambler
package scramble_lanes_pkg;

    localparam logic [15:0] LFSR_SEED = 16'hFFFF;
    // Galois feedback for X^16+X^5+X^4+X^3+1: X^16 wraps onto bits 5,4,3,0
    localparam logic [15:0] LFSR_TAPS = 16'h0039;
    localparam logic [7:0]  COM       = 8'hBC;
    localparam logic [7:0]  SKP       = 8'h1C;

    typedef enum logic [1:0] {
        SYM_DATA,
        SYM_COM,
        SYM_SKP,
        SYM_CTRL
    } symClass_t;

    function automatic symClass_t classifySymbol(input logic isK, input logic [7:0] sym);
        if (!isK)
            return SYM_DATA;
        else if (sym == COM)
            return SYM_COM;
        else if (sym == SKP)
            return SYM_SKP;
        else
            return SYM_CTRL;
    endfunction

    function automatic logic [15:0] lfsrAdvance(input logic [15:0] state);
        logic [15:0] l;
        logic        msb;
        l = state;
        for (int i = 0; i < 8; i++) begin
            msb = l[15];
            l   = {l[14:0], 1'b0};
            if (msb)
                l = l ^ LFSR_TAPS;
        end
        return l;
    endfunction

    // The top byte shifts out untouched by feedback during one 8-shift advance
    function automatic logic [7:0] lfsrKey(input logic [15:0] state);
        logic [7:0] k;
        for (int i = 0; i < 8; i++)
            k[i] = state[15-i];
        return k;
    endfunction

endpackage

// File: rtl/scramble_lanes_lane.sv
// rtl/scramble_lanes_lane.sv - one scrambler lane: LFSR, key, K handling, output register
module scramble_lane
    import scramble_lanes_pkg::*;
(
    input  logic        ClkPci,
    input  logic        notResetPci,
    input  logic        InValid,
    input  logic [7:0]  InData,
    input  logic        InK,
    input  logic        Bypass,
    output logic        CombValid,
    output logic [7:0]  CombData,
    output logic        CombK,
    output logic        RegValid,
    output logic [7:0]  RegData,
    output logic        RegK,
    output logic [15:0] LfsrState
);

    logic [15:0] lfsr;
    logic [15:0] lfsrNext;
    logic [7:0]  dataNext;
    symClass_t   symClass;

    always_comb begin
        lfsrNext = lfsr;
        dataNext = InData;
        symClass = classifySymbol(InK, InData);
        if (InValid) begin
            unique case (symClass)
                SYM_DATA: begin
                    lfsrNext = lfsrAdvance(lfsr);
                    if (!Bypass)
                        dataNext = InData ^ lfsrKey(lfsr);
                end
                SYM_COM:  lfsrNext = LFSR_SEED;
                SYM_SKP:  lfsrNext = lfsr;
                SYM_CTRL: lfsrNext = lfsrAdvance(lfsr);
            endcase
        end
    end

    always_ff @(posedge ClkPci or negedge notResetPci) begin
        if (!notResetPci) begin
            lfsr     <= LFSR_SEED;
            RegValid <= 1'b0;
            RegData  <= 8'h00;
            RegK     <= 1'b0;
        end else begin
            lfsr     <= lfsrNext;
            RegValid <= InValid;
            if (InValid) begin
                RegData <= dataNext;
                RegK    <= InK;
            end
        end
    end

    // Zero-latency view: idle cycles show the held register, and reset forces zero
    always_comb begin
        CombValid = notResetPci & InValid;
        CombData  = 8'h00;
        CombK     = 1'b0;
        if (notResetPci) begin
            CombData = InValid ? dataNext : RegData;
            CombK    = InValid ? InK : RegK;
        end
    end

    assign LfsrState = lfsr;

endmodule

// File: rtl/scramble_lanes.sv
// rtl/scramble_lanes.sv - multi-lane byte scrambler with per-lane independent LFSRs
module scramble_lanes
    import scramble_lanes_pkg::*;
#(
    parameter int LANES        = 4,
    parameter int REGISTER_OUT = 1
) (
    input  logic                  ClkPci,
    input  logic                  notResetPci,
    input  logic [LANES-1:0]      InValid,
    input  logic [8*LANES-1:0]    InData,
    input  logic [LANES-1:0]      InK,
    input  logic                  Bypass,
    output logic [LANES-1:0]      OutValid,
    output logic [8*LANES-1:0]    OutData,
    output logic [LANES-1:0]      OutK,
    output logic [16*LANES-1:0]   LfsrState
);

    for (genvar n = 0; n < LANES; n++) begin : gLane
        logic       combValid;
        logic [7:0] combData;
        logic       combK;
        logic       regValid;
        logic [7:0] regData;
        logic       regK;

        scramble_lane uLane (
            .ClkPci      (ClkPci),
            .notResetPci (notResetPci),
            .InValid     (InValid[n]),
            .InData      (InData[8*n +: 8]),
            .InK         (InK[n]),
            .Bypass      (Bypass),
            .CombValid   (combValid),
            .CombData    (combData),
            .CombK       (combK),
            .RegValid    (regValid),
            .RegData     (regData),
            .RegK        (regK),
            .LfsrState   (LfsrState[16*n +: 16])
        );

        assign OutValid[n]       = (REGISTER_OUT != 0) ? regValid : combValid;
        assign OutData[8*n +: 8] = (REGISTER_OUT != 0) ? regData  : combData;
        assign OutK[n]           = (REGISTER_OUT != 0) ? regK     : combK;
    end

endmodule

// File: tb/tb_scramble_lanes.sv
// tb/tb_scramble_lanes.sv - directed vector bench for scramble_lanes (registered x4, combinational x1)
module tb_scramble_lanes;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  k;
        logic        bypass;
        logic [3:0]  expValid;
        logic [31:0] expData;
        logic [3:0]  expK;
        logic [63:0] expLfsr;
    } vec_t;

    logic        ClkPci = 1'b0;
    logic        notResetPci = 1'b0;
    logic [3:0]  InValid = '0;
    logic [31:0] InData = '0;
    logic [3:0]  InK = '0;
    logic        Bypass = 1'b0;
    logic [3:0]  OutValid;
    logic [31:0] OutData;
    logic [3:0]  OutK;
    logic [63:0] LfsrState;

    logic        cOutValid;
    logic [7:0]  cOutData;
    logic        cOutK;
    logic [15:0] cLfsrState;

    int nVec = 0;
    int nMis = 0;
    vec_t tbl[9];

    always #5 ClkPci = ~ClkPci;

    scramble_lanes #(.LANES(4), .REGISTER_OUT(1)) dut (
        .ClkPci      (ClkPci),
        .notResetPci (notResetPci),
        .InValid     (InValid),
        .InData      (InData),
        .InK         (InK),
        .Bypass      (Bypass),
        .OutValid    (OutValid),
        .OutData     (OutData),
        .OutK        (OutK),
        .LfsrState   (LfsrState)
    );

    scramble_lanes #(.LANES(1), .REGISTER_OUT(0)) dutComb (
        .ClkPci      (ClkPci),
        .notResetPci (notResetPci),
        .InValid     (InValid[0]),
        .InData      (InData[7:0]),
        .InK         (InK[0]),
        .Bypass      (Bypass),
        .OutValid    (cOutValid),
        .OutData     (cOutData),
        .OutK        (cOutK),
        .LfsrState   (cLfsrState)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyVec(input int idx);
        @(negedge ClkPci);
        InValid = tbl[idx].valid;
        InData  = tbl[idx].data;
        InK     = tbl[idx].k;
        Bypass  = tbl[idx].bypass;
        #1;
        check($sformatf("comb_valid[%0d]", idx), {63'd0, cOutValid}, {63'd0, tbl[idx].expValid[0]});
        check($sformatf("comb_data[%0d]", idx), {56'd0, cOutData}, {56'd0, tbl[idx].expData[7:0]});
        @(posedge ClkPci);
        #1;
        check($sformatf("valid[%0d]", idx), {60'd0, OutValid}, {60'd0, tbl[idx].expValid});
        check($sformatf("data[%0d]", idx), {32'd0, OutData}, {32'd0, tbl[idx].expData});
        check($sformatf("k[%0d]", idx), {60'd0, OutK}, {60'd0, tbl[idx].expK});
        check($sformatf("lfsr[%0d]", idx), LfsrState, tbl[idx].expLfsr);
    endtask

    initial begin
        // Lanes packed {l3,l2,l1,l0}; key sequence from seed: FF,17,C0,14,B2
        // with LFSR FFFF -> E817 -> 0328 -> 284B -> 4DE8 -> E755
        tbl[0] = '{4'hF, 32'hBCBCBCBC, 4'hF, 1'b0, 4'hF, 32'hBCBCBCBC, 4'hF,
                   64'hFFFF_FFFF_FFFF_FFFF};
        tbl[1] = '{4'hF, 32'h00000000, 4'h0, 1'b0, 4'hF, 32'hFFFFFFFF, 4'h0,
                   64'hE817_E817_E817_E817};
        // lane3 other-K advances, lane2 idle holds, lane1 SKP holds, lane0 data
        tbl[2] = '{4'b1011, 32'hFC001C00, 4'b1010, 1'b0, 4'b1011, 32'hFCFF1C17, 4'b1010,
                   64'h0328_E817_E817_0328};
        tbl[3] = '{4'hF, 32'h5A5A5A5A, 4'h0, 1'b1, 4'hF, 32'h5A5A5A5A, 4'h0,
                   64'h284B_0328_0328_284B};
        tbl[4] = '{4'hF, 32'h00000000, 4'h0, 1'b0, 4'hF, 32'h14C0C014, 4'h0,
                   64'h4DE8_284B_284B_4DE8};
        tbl[5] = '{4'hF, 32'h00BC0000, 4'b0100, 1'b0, 4'hF, 32'hB2BC14B2, 4'b0100,
                   64'hE755_FFFF_4DE8_E755};
        tbl[6] = '{4'b0110, 32'h00000000, 4'h0, 1'b0, 4'b0110, 32'hB2FFB2B2, 4'h0,
                   64'hE755_E817_E755_E755};
        tbl[7] = '{4'hF, 32'h00000000, 4'h0, 1'b0, 4'hF, 32'hFFFFFFFF, 4'h0,
                   64'hE817_E817_E817_E817};
        tbl[8] = '{4'hF, 32'h00000000, 4'h0, 1'b0, 4'hF, 32'h17171717, 4'h0,
                   64'h0328_0328_0328_0328};

        repeat (2) @(posedge ClkPci);
        #1;
        check("rst_valid", {60'd0, OutValid}, 64'd0);
        check("rst_data", {32'd0, OutData}, 64'd0);
        check("rst_k", {60'd0, OutK}, 64'd0);
        check("rst_lfsr", LfsrState, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_comb_data", {56'd0, cOutData}, 64'd0);
        @(negedge ClkPci);
        notResetPci = 1'b1;

        for (int i = 0; i < 7; i++)
            applyVec(i);

        // Sub-cycle reset pulse mid-burst: everything clears before any clock edge
        @(negedge ClkPci);
        InValid = 4'h0;
        #1 notResetPci = 1'b0;
        #1;
        check("pulse_valid", {60'd0, OutValid}, 64'd0);
        check("pulse_data", {32'd0, OutData}, 64'd0);
        check("pulse_k", {60'd0, OutK}, 64'd0);
        check("pulse_lfsr", LfsrState, 64'hFFFF_FFFF_FFFF_FFFF);
        check("pulse_comb_lfsr", {48'd0, cLfsrState}, 64'h0000_0000_0000_FFFF);
        #1 notResetPci = 1'b1;

        for (int i = 7; i < 9; i++)
            applyVec(i);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
